// File: rtl/cache_mem_responder_if.sv
// Cache-side block transfer bus between a cache controller and its backing memory.
interface cache_mem_responder_if;
    logic         req_valid;
    logic         req_write;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata;
    logic         req_ready;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         busy;
    logic [7:0]   rd_count;
    logic [7:0]   wr_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy, rd_count, wr_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy, rd_count, wr_count
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Fixed-latency block memory behind a cache: one 4-word block transfer at a time.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | latency countdown, request fields latched
// RESP  | one-cycle completion pulse, memory already updated
module cache_mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned WORDS   = 256
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    cache_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         wr_q, wr_d;
    logic [5:0]   blk_q, blk_d;
    logic [127:0] wdata_q, wdata_d;
    logic [127:0] rdata_q, rdata_d;
    logic [7:0]   rd_cnt_q, rd_cnt_d;
    logic [7:0]   wr_cnt_q, wr_cnt_d;
    logic         mem_we;
    logic [127:0] rd_blk;

    // Words never written read back as their own index (power-up image);
    // the written flag lives outside reset so reset leaves memory intact.
    logic [31:0]      mem_q [WORDS];
    logic [WORDS-1:0] mem_wr_q = '0;

    // Assemble the addressed block, word 0 in the low bits.
    always_comb begin
        rd_blk = '0;
        for (int k = 0; k < 4; k++) begin
            rd_blk[32*k +: 32] = mem_wr_q[{blk_q, 2'(k)}] ? mem_q[{blk_q, 2'(k)}]
                                                           : {24'd0, blk_q, 2'(k)};
        end
    end

    // A write lands on the BUSY->RESP edge unless reset is asserted on that edge.
    assign mem_we = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q && rst_n_i;

    // Memory array update; deliberately no reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{blk_q, 2'(k)}]    <= wdata_q[32*k +: 32];
                mem_wr_q[{blk_q, 2'(k)}] <= 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            blk_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            blk_q    <= blk_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Next-state logic: accept, count down, complete, return to idle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        blk_d    = blk_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    blk_d   = bus.req_addr[9:4];
                    wdata_d = bus.req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (wr_q) begin
                        rdata_d = wdata_q;
                        if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
                    end else begin
                        rdata_d = rd_blk;
                        if (rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_rdata = rdata_q;
    assign bus.rd_count   = rd_cnt_q;
    assign bus.wr_count   = wr_cnt_q;
endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench: two responders (latency 4 and latency 1) driven with directed block transfers.
module tb_cache_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b;
    cache_mem_responder_if ifa ();
    cache_mem_responder_if ifb ();

    cache_mem_responder #(.LATENCY(4), .WORDS(256)) dut_a (.clk_i(clk), .rst_n_i(rst_n_a), .bus(ifa));
    cache_mem_responder #(.LATENCY(1), .WORDS(256)) dut_b (.clk_i(clk), .rst_n_i(rst_n_b), .bus(ifb));

    typedef struct {
        logic [127:0] data;
        logic [7:0]   rd;
        logic [7:0]   wr;
        int           cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   ecnt_rd[2];
    int   ecnt_wr[2];
    logic [127:0] last_d[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    function automatic logic [127:0] w4(input int w0, input int w1, input int w2, input int w3);
        return {32'(w3), 32'(w2), 32'(w1), 32'(w0)};
    endfunction

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    function automatic logic rdy(input int s);
        return (s == 0) ? ifa.req_ready : ifb.req_ready;
    endfunction

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input int s, input logic w, input logic [9:0] a,
                         input logic [127:0] wd, input logic [127:0] exp_d, input bit push);
        exp_t e;
        int   n;
        if (s == 0) begin
            ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = wd; ifa.req_valid = 1'b1;
        end else begin
            ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = wd; ifb.req_valid = 1'b1;
        end
        n = 0;
        while (!rdy(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(s)) begin
            total++;
            $display("FAIL accept_timeout dut%0d: req_ready stayed 0, required 1", s);
        end else begin
            if (push) begin
                if (w) ecnt_wr[s]++;
                else   ecnt_rd[s]++;
                e.data = exp_d;
                e.rd   = sat8(ecnt_rd[s]);
                e.wr   = sat8(ecnt_wr[s]);
                e.cyc  = cyc + 1 + ((s == 0) ? 4 : 1);
                if (s == 0) q_a.push_back(e);
                else        q_b.push_back(e);
                last_d[s] = exp_d;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (s == 0) ifa.req_valid = 1'b0;
        else        ifb.req_valid = 1'b0;
    endtask

    task automatic drain(input int s);
        int n = 0;
        while (((s == 0) ? (q_a.size() != 0 || ifa.busy) : (q_b.size() != 0 || ifb.busy)) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            $display("FAIL drain_timeout dut%0d: responder still busy, required idle", s);
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input int s);
        if (s == 0) begin
            chk("a_rst_ready", 128'(ifa.req_ready), 128'd1);
            chk("a_rst_valid_busy", 128'({ifa.resp_valid, ifa.busy}), 128'd0);
            chk("a_rst_rdata", ifa.resp_rdata, 128'd0);
            chk("a_rst_counts", 128'({ifa.rd_count, ifa.wr_count}), 128'd0);
        end else begin
            chk("b_rst_ready", 128'(ifb.req_ready), 128'd1);
            chk("b_rst_counts", 128'({ifb.rd_count, ifb.wr_count}), 128'd0);
        end
    endtask

    // Monitors: pop on every completion pulse and check the cycle after it.
    initial begin
        exp_t e;
        bit prev = 0;
        forever begin
            @(negedge clk);
            if (prev) chk("a_resp_drop", 128'({ifa.resp_valid, ifa.req_ready}), 128'b01);
            prev = ifa.resp_valid;
            if (ifa.resp_valid) begin
                if (q_a.size() == 0) begin
                    total++;
                    $display("FAIL a_unexpected_resp: got resp_valid=1 required 0 at cycle %0d", cyc);
                end else begin
                    e = q_a.pop_front();
                    chk("a_rdata", ifa.resp_rdata, e.data);
                    chk("a_rd_count", 128'(ifa.rd_count), 128'(e.rd));
                    chk("a_wr_count", 128'(ifa.wr_count), 128'(e.wr));
                    chk("a_resp_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    initial begin
        exp_t e;
        bit prev = 0;
        forever begin
            @(negedge clk);
            if (prev) chk("b_resp_drop", 128'({ifb.resp_valid, ifb.req_ready}), 128'b01);
            prev = ifb.resp_valid;
            if (ifb.resp_valid) begin
                if (q_b.size() == 0) begin
                    total++;
                    $display("FAIL b_unexpected_resp: got resp_valid=1 required 0 at cycle %0d", cyc);
                end else begin
                    e = q_b.pop_front();
                    chk("b_rdata", ifb.resp_rdata, e.data);
                    chk("b_rd_count", 128'(ifb.rd_count), 128'(e.rd));
                    chk("b_wr_count", 128'(ifb.wr_count), 128'(e.wr));
                    chk("b_resp_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d_wr, d1, d2, d3, top_blk;
        d_wr    = w4(100, 101, 102, 103);
        d1      = w4('hA5A50000, 'hA5A50001, 'hA5A50002, 'hA5A50003);
        d2      = w4('h11110000, 'h22220000, 'h33330000, 'h44440000);
        d3      = w4('hDEAD0000, 'hDEAD0001, 'hDEAD0002, 'hDEAD0003);
        top_blk = w4(252, 253, 254, 255);
        for (int s = 0; s < 2; s++) begin
            ecnt_rd[s] = 0; ecnt_wr[s] = 0; last_d[s] = '0;
        end
        ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        chk_reset(0);
        chk_reset(1);

        // Read after reset, write then read, neighbouring block untouched.
        issue(0, 1'b0, 10'h010, '0, w4(4, 5, 6, 7), 1);
        issue(0, 1'b1, 10'h020, d_wr, d_wr, 1);
        issue(0, 1'b0, 10'h02C, '0, d_wr, 1);
        issue(0, 1'b0, 10'h030, '0, w4(12, 13, 14, 15), 1);
        drain(0);
        repeat (3) @(negedge clk);
        chk("a_rdata_hold", ifa.resp_rdata, last_d[0]);

        // Request held while busy; its fields must not disturb the write in flight.
        issue(0, 1'b1, 10'h050, d1, d1, 1);
        issue(0, 1'b0, 10'h060, '0, w4(24, 25, 26, 27), 1);
        drain(0);

        // Reset two edges after accepting a write: nothing completes or lands.
        issue(0, 1'b1, 10'h030, '0, w4(9, 9, 9, 9), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n_a = 1'b1;
        ecnt_rd[0] = 0; ecnt_wr[0] = 0;
        chk_reset(0);
        repeat (8) @(negedge clk);
        issue(0, 1'b0, 10'h030, '0, w4(12, 13, 14, 15), 1);
        drain(0);

        // Reset while the completion pulse is up: the write already landed.
        issue(0, 1'b1, 10'h070, d2, d2, 1);
        repeat (4) @(negedge clk);
        rst_n_a = 1'b0;
        @(negedge clk);
        rst_n_a = 1'b1;
        ecnt_rd[0] = 0; ecnt_wr[0] = 0;
        chk("a_rst_in_resp_wr", 128'(ifa.wr_count), 128'd0);
        issue(0, 1'b0, 10'h070, '0, d2, 1);
        drain(0);

        // Top block and read-count saturation.
        issue(0, 1'b0, 10'h3F4, '0, top_blk, 1);
        for (int i = 0; i < 260; i++) issue(0, 1'b0, 10'h3F0, '0, top_blk, 1);
        drain(0);
        chk("a_rd_saturated", 128'(ifa.rd_count), 128'd255);

        // Single-cycle latency responder.
        issue(1, 1'b0, 10'h3F4, '0, top_blk, 1);
        issue(1, 1'b1, 10'h3F8, d3, d3, 1);
        issue(1, 1'b0, 10'h3F0, '0, d3, 1);
        issue(1, 1'b0, 10'h000, '0, w4(0, 1, 2, 3), 1);
        drain(1);

        chk("a_queue_empty", 128'(q_a.size()), 128'd0);
        chk("b_queue_empty", 128'(q_b.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, meaning: cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter WORDS, default 256, meaning: 32-bit memory words, covering the 10-bit byte address space.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  cache requests a block transfer.
REQ-006 req_write  input  1  1 = write-back block, 0 = refill (read) block.
REQ-007 req_addr  input  10  byte address; bits [9:4] select the block, bits [3:0] ignored.
REQ-008 req_wdata  input  128  write block; word k at bits [32k+31:32k].
REQ-009 req_ready  output  1  responder idle and able to accept.
REQ-010 resp_valid  output  1  one-cycle pulse: transfer complete.
REQ-011 resp_rdata  output  128  block data, same word packing as req_wdata.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 rd_count  output  8  completed reads, saturating at 255.
REQ-014 wr_count  output  8  completed writes, saturating at 255.

Function
REQ-015 Storage SHALL be WORDS x 32 bits; block base word index = {req_addr[9:4], 2'b00}; word k = memory[base+k].
REQ-016 Simulation initial contents SHALL be memory[i] = i; reset SHALL NOT modify memory contents.
REQ-017 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-018 In IDLE, req_ready SHALL be 1; in BUSY and RESP it SHALL be 0.
REQ-019 Acceptance occurs on a rising edge with req_valid=1 and req_ready=1: latch req_write, req_addr[9:4], req_wdata; load the counter with LATENCY-1; go to BUSY.
REQ-020 In BUSY, the counter SHALL decrement each edge; on the edge where the counter = 0, the FSM SHALL go to RESP.
REQ-021 On the BUSY->RESP edge, a read SHALL load resp_rdata from memory, and a write SHALL store the latched block into memory and set resp_rdata to the latched block.
REQ-022 resp_valid SHALL be 1 only in RESP, for exactly one cycle; RESP->IDLE is unconditional on the next edge.
REQ-023 Timing: accept at edge N -> resp_valid high after edge N+LATENCY, low after edge N+LATENCY+1, req_ready high again after edge N+LATENCY+1.
REQ-024 resp_rdata SHALL hold its last value outside RESP.
REQ-025 req_valid and request fields SHALL be ignored while req_ready=0; a held request is accepted on the first IDLE edge.
REQ-026 rd_count or wr_count SHALL increment on the BUSY->RESP edge for the matching operation, holding at 255 once reached.
REQ-027 LATENCY=1 SHALL give exactly one BUSY cycle.
REQ-028 Reads and writes to block 63 (addr 0x3F0-0x3FF) SHALL access words 252..255 with no wrap.

Reset
REQ-029 When rst_n=0 at an edge, the block SHALL set: state IDLE, counter 0, req_ready 1, resp_valid 0, busy 0, resp_rdata 0, rd_count 0, wr_count 0.
REQ-030 Reset during BUSY SHALL abandon the transfer; a pending write SHALL NOT reach memory and SHALL NOT count.
REQ-031 Reset during RESP SHALL clear resp_valid on that edge; the already-performed memory write SHALL remain.

Verification
REQ-032 Read after reset, LATENCY=4: read at addr 0x010 accepted at edge N -> resp_valid at N+4 for one cycle with words {4,5,6,7}, rd_count=1.
REQ-033 Write then read: write addr 0x020 with words {100,101,102,103}, then read 0x02C -> read returns {100,101,102,103}, memory[8..11] updated, wr_count=1, rd_count=1.
REQ-034 Held request: second req_valid asserted while busy -> not accepted until req_ready=1, then accepted on the first IDLE edge; two resp_valid pulses spaced exactly LATENCY+2 cycles apart.
REQ-035 Reset mid-write: write 0x030 with {9,9,9,9}, rst_n low for 1 cycle 2 edges after acceptance -> no resp_valid, memory[12..15] still {12,13,14,15}, wr_count=0.
REQ-036 Boundary: read 0x3F4 -> {252,253,254,255}; 260 reads -> rd_count=255; LATENCY=1 read -> resp_valid at N+1.
